// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM read port between NUM_REQ clients.
// Define RAM_READ_ARBITER_OUTREG_EN to register the response once more (latency 2).
module ram_read_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      win;
  logic [PTR_W-1:0]      pend_id;
  logic                  found;
  logic                  pend_vld;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    pend_onehot;
  logic [ADDR_WIDTH-1:0] win_addr;

  // Two passes: clients at or above ptr first, then the wrapped-around ones below it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant    = '0;
    win      = '0;
    win_addr = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        win      = PTR_W'(i);
        grant[i] = 1'b1;
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i < int'(ptr))) begin
        found    = 1'b1;
        win      = PTR_W'(i);
        grant[i] = 1'b1;
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Grant and address are held at zero while reset is asserted.
  assign req_ready = rst_n ? grant : '0;
  assign ram_raddr = rst_n ? win_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      ptr      <= '0;
      pend_id  <= '0;
      pend_vld <= 1'b0;
    end else begin
      pend_vld <= found;
      if (found) begin
        pend_id <= win;
        ptr     <= (win == LAST_ID) ? '0 : win + 1'b1;
      end
    end
  end

  always_comb begin
    pend_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_onehot[i] = pend_vld && (pend_id == PTR_W'(i));
    end
  end

`ifdef RAM_READ_ARBITER_OUTREG_EN
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= pend_onehot;
      rsp_data_q  <= ram_rdata;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  assign rsp_valid = pend_onehot;
  assign rsp_data  = rst_n ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Self-checking bench: random and directed traffic against a queue-based round-robin model.
module tb_ram_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef RAM_READ_ARBITER_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_ready;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata = '0;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;

  ram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Winner is the valid client closest to ptr going upward with wrap.
  function automatic int pick(input int p, input logic [N-1:0] v);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && (((i - p + N) % N) < bd)) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  // Model state: priority pointer plus a LAT-deep list of expected responses.
  int            mptr;
  logic          st_vld  [LAT];
  int            st_id   [LAT];
  logic [DW-1:0] st_data [LAT];

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      mptr = 0;
      for (int k = 0; k < LAT; k++) begin
        st_vld[k] = 1'b0; st_id[k] = 0; st_data[k] = '0;
      end
    end else begin
      w = pick(mptr, req_valid);
      for (int k = LAT - 1; k > 0; k--) begin
        st_vld[k] = st_vld[k-1]; st_id[k] = st_id[k-1]; st_data[k] = st_data[k-1];
      end
      st_vld[0]  = (w >= 0);
      st_id[0]   = (w >= 0) ? w : 0;
      st_data[0] = (w >= 0) ? mem[addr_of(w)] : '0;
      if (w >= 0) mptr = (w + 1) % N;
    end
  end

  typedef struct {
    int            c;
    logic [N-1:0]  v;
    logic [DW-1:0] d;
  } rsp_t;
  rsp_t rsp_log[$];
  logic [N-1:0] last_acc = '0;

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    int w;
    logic [N-1:0] exp_rv;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_ram_raddr", ram_raddr, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
    end else begin
      w = pick(mptr, req_valid);
      check("req_ready", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
      check("ram_raddr", ram_raddr, (w >= 0) ? addr_of(w) : '0);
      exp_rv = st_vld[LAT-1] ? N'(1 << st_id[LAT-1]) : '0;
      check("rsp_valid", rsp_valid, exp_rv);
      if (st_vld[LAT-1]) check("rsp_data", rsp_data, st_data[LAT-1]);
    end
    last_acc = req_ready & req_valid;
    if (rsp_valid != '0) rsp_log.push_back('{c: cyc, v: rsp_valid, d: rsp_data});
  end

  task automatic set_req(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int g0;
    logic [DW-1:0] exp_d [6];
    logic [N-1:0]  exp_v [6];

    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h10] = 8'h5A; mem[8'h11] = 8'h5B; mem[8'h12] = 8'h5C;
    mem[8'h20] = 8'hA0; mem[8'h30] = 8'hB0;
    mem[8'h40] = 8'hC4; mem[8'h41] = 8'hC5;

    // Reset held with two clients requesting.
    set_req(3'b011, 8'h20, 8'h30, 8'h00);
    rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    check("hold_rst_ready", req_ready, 0);
    check("hold_rst_raddr", ram_raddr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant", req_ready, 3'b001);
    check("first_raddr", ram_raddr, 8'h20);
    step();
    set_req(3'b000, 0, 0, 0);
    repeat (3) step();

    // Single client, three back-to-back reads.
    rsp_log.delete();
    set_req(3'b010, 8'h00, 8'h10, 8'h00);
    g0 = cyc;
    @(negedge clk); check("single_rdy0", req_ready, 3'b010);
    step(); set_req(3'b010, 8'h00, 8'h11, 8'h00);
    @(negedge clk); check("single_rdy1", req_ready, 3'b010);
    step(); set_req(3'b010, 8'h00, 8'h12, 8'h00);
    @(negedge clk); check("single_rdy2", req_ready, 3'b010);
    step(); set_req(3'b000, 0, 0, 0);
    repeat (3) step();
    exp_d[0] = 8'h5A; exp_d[1] = 8'h5B; exp_d[2] = 8'h5C;
    check("single_rsp_count", rsp_log.size(), 3);
    for (int i = 0; i < rsp_log.size() && i < 3; i++) begin
      check("single_rsp_data", rsp_log[i].d, exp_d[i]);
      check("single_rsp_valid", rsp_log[i].v, 3'b010);
      check("single_rsp_cycle", rsp_log[i].c, g0 + LAT + i);
    end

    // Contention between clients 0 and 1.
    rsp_log.delete();
    set_req(3'b011, 8'h20, 8'h30, 8'h00);
    g0 = cyc;
    for (int i = 0; i < 6; i++) begin
      exp_d[i] = (i % 2 == 0) ? 8'hA0 : 8'hB0;
      exp_v[i] = (i % 2 == 0) ? 3'b001 : 3'b010;
      @(negedge clk); check("cont_grant", req_ready, exp_v[i]);
      step();
    end
    set_req(3'b000, 0, 0, 0);
    repeat (3) step();
    check("cont_rsp_count", rsp_log.size(), 6);
    for (int i = 0; i < rsp_log.size() && i < 6; i++) begin
      check("cont_rsp_data", rsp_log[i].d, exp_d[i]);
      check("cont_rsp_valid", rsp_log[i].v, exp_v[i]);
      check("cont_rsp_cycle", rsp_log[i].c, g0 + LAT + i);
    end

    // Wrap: client 2 alone, then client 0 alone with no gap, then 0 and 1.
    rsp_log.delete();
    set_req(3'b100, 8'h00, 8'h00, 8'h40);
    g0 = cyc;
    @(negedge clk); check("wrap_c2", req_ready, 3'b100);
    step(); set_req(3'b001, 8'h41, 8'h00, 8'h00);
    @(negedge clk); check("wrap_c0", req_ready, 3'b001);
    step(); set_req(3'b011, 8'h20, 8'h30, 8'h00);
    @(negedge clk); check("wrap_then_c1", req_ready, 3'b010);
    step(); set_req(3'b000, 0, 0, 0);
    repeat (3) step();
    check("wrap_rsp_count", rsp_log.size(), 3);
    if (rsp_log.size() >= 2) begin
      check("wrap_rsp0_data", rsp_log[0].d, 8'hC4);
      check("wrap_rsp1_data", rsp_log[1].d, 8'hC5);
      check("wrap_rsp0_cycle", rsp_log[0].c, g0 + LAT);
      check("wrap_rsp1_cycle", rsp_log[1].c, g0 + LAT + 1);
    end

    // Reset asserted right after an accepting edge discards the response.
    rsp_log.delete();
    set_req(3'b010, 8'h00, 8'h12, 8'h00);
    step();
    rst_n = 1'b0;
    set_req(3'b000, 0, 0, 0);
    @(negedge clk); check("midrst_rsp_valid", rsp_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("midrst_no_rsp", rsp_log.size(), 0);
    step(); set_req(3'b011, 8'h20, 8'h30, 8'h00);
    @(negedge clk); check("post_rst_grant", req_ready, 3'b001);
    step(); set_req(3'b000, 0, 0, 0);
    repeat (3) step();
    check("post_rst_rsp_count", rsp_log.size(), 1);
    if (rsp_log.size() >= 1) check("post_rst_rsp_data", rsp_log[0].d, 8'hA0);

    // Random traffic; clients hold request and address until accepted.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 255));
        end
      end
      step();
    end
    set_req(3'b000, 0, 0, 0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
